// File: rtl/comp_ctrl.sv
// Job sequencer: streams W_LEN weights once, then I_LEN inputs per tile to the compute block,
// waiting for com_end (bounded by TIMEOUT) between tiles.
module comp_ctrl #(
  parameter int W_LEN   = 16,
  parameter int I_LEN   = 256,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         num_tile,
  output logic               mem_rd,
  output logic [15:0]        mem_addr,
  input  logic signed [15:0] mem_rdata,
  output logic               w_load,
  output logic signed [15:0] w_in,
  output logic               i_load,
  output logic signed [15:0] i_in,
  input  logic               com_end,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [7:0]         tile_idx
);

  typedef enum logic [2:0] {IDLE, W_RD, I_RD, WAIT, DONE, ERR} state_t;

  state_t      state, state_nxt;
  logic [31:0] cnt;
  logic [7:0]  ntile;
  logic        accept, tile_next, last_tile;
  logic        w_load_q, i_load_q;
  logic [15:0] i_addr;

  assign last_tile = (tile_idx == ntile - 8'd1);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    tile_next = 1'b0;
    case (state)
      IDLE, ERR: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = W_RD;
        end
      end
      W_RD: if (cnt == 32'(W_LEN - 1)) state_nxt = I_RD;
      I_RD: if (cnt == 32'(I_LEN - 1)) state_nxt = WAIT;
      WAIT: begin
        // com_end takes priority over a timeout landing in the same cycle
        if (com_end) begin
          if (last_tile) begin
            state_nxt = DONE;
          end else begin
            state_nxt = I_RD;
            tile_next = 1'b1;
          end
        end else if (cnt == 32'(TIMEOUT - 1)) begin
          state_nxt = ERR;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      ntile    <= '0;
      tile_idx <= '0;
      w_load_q <= 1'b0;
      i_load_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      // one counter serves as read index in W_RD/I_RD and as wait timer in WAIT
      if (state_nxt != state || !busy) cnt <= '0;
      else                             cnt <= cnt + 32'd1;
      if (accept) begin
        ntile    <= (num_tile == 8'd0) ? 8'd1 : num_tile;
        tile_idx <= '0;
      end else if (tile_next) begin
        tile_idx <= tile_idx + 8'd1;
      end
      w_load_q <= (state == W_RD);
      i_load_q <= (state == I_RD);
    end
  end

  assign i_addr   = 16'(W_LEN) + {8'd0, tile_idx} * 16'(I_LEN) + cnt[15:0];

  assign mem_rd   = (state == W_RD) || (state == I_RD);
  assign mem_addr = (state == W_RD) ? cnt[15:0] :
                    (state == I_RD) ? i_addr : 16'd0;

  assign w_load   = w_load_q;
  assign i_load   = i_load_q;
  assign w_in     = w_load_q ? mem_rdata : 16'sd0;
  assign i_in     = i_load_q ? mem_rdata : 16'sd0;

  assign busy     = (state == W_RD) || (state == I_RD) || (state == WAIT);
  assign done     = (state == DONE);
  assign err      = (state == ERR);

endmodule

// File: tb/tb_comp_ctrl.sv
// Randomized bench for comp_ctrl: a job-level model predicts every cycle's outputs from the read schedule.
module tb_comp_ctrl;
  localparam int W_LEN = 16;
  localparam int I_LEN = 256;
  localparam int TO    = 300;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [7:0]         num_tile;
  logic               mem_rd;
  logic [15:0]        mem_addr;
  logic signed [15:0] mem_rdata;
  logic               w_load, i_load;
  logic signed [15:0] w_in, i_in;
  logic               com_end;
  logic               busy, done, err;
  logic [7:0]         tile_idx;

  int checks = 0;
  int errors = 0;
  int prev_ph = 0;
  int prev_addr = 0;
  int exp_tile = 0;

  comp_ctrl #(.W_LEN(W_LEN), .I_LEN(I_LEN), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .num_tile(num_tile),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .w_load(w_load), .w_in(w_in), .i_load(i_load), .i_in(i_in),
    .com_end(com_end), .busy(busy), .done(done), .err(err), .tile_idx(tile_idx)
  );

  always #5 clk = ~clk;

  function automatic logic signed [15:0] memf(input int a);
    logic [15:0] x;
    x = 16'(a);
    return $signed((x * 16'd13) ^ 16'h3c5a);
  endfunction

  // source memory: one-cycle read latency, garbage when not reading
  always @(posedge clk)
    mem_rdata <= mem_rd ? memf(int'(mem_addr)) : 16'($urandom);

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ph: 0 no read, 1 weight read, 2 input read
  task automatic step(input int ph, input int addr, input bit bsy, input bit dn, input bit er, input int tidx);
    @(negedge clk);
    check("mem_rd", int'(mem_rd), int'(ph != 0));
    if (ph != 0) check("mem_addr", int'(mem_addr), addr & 16'hFFFF);
    check("w_load", int'(w_load), int'(prev_ph == 1));
    check("i_load", int'(i_load), int'(prev_ph == 2));
    check("w_in", int'(w_in), (prev_ph == 1) ? int'(memf(prev_addr)) : 0);
    check("i_in", int'(i_in), (prev_ph == 2) ? int'(memf(prev_addr)) : 0);
    check("busy", int'(busy), int'(bsy));
    check("done", int'(done), int'(dn));
    check("err", int'(err), int'(er));
    check("tile_idx", int'(tile_idx), tidx);
    prev_ph = ph;
    prev_addr = addr & 16'hFFFF;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit er);
    for (int i = 0; i < n; i++) begin
      com_end = ($urandom_range(0, 3) == 0);
      step(0, 0, 1'b0, 1'b0, er, exp_tile);
    end
    com_end = 1'b0;
  endtask

  task automatic noise();
    start   = ($urandom_range(0, 7) == 0);
    com_end = ($urandom_range(0, 7) == 0);
  endtask

  // to_tile: tile index whose WAIT times out (-1 none); fixed_k: WAIT cycles before com_end (-1 random)
  task automatic run_job(input int n, input bit from_err, input int to_tile, input int fixed_k);
    int nt;
    int k;
    nt = (n == 0) ? 1 : n;
    start = 1'b1;
    num_tile = 8'(n);
    step(0, 0, 1'b0, 1'b0, from_err, exp_tile);
    start = 1'b0;
    exp_tile = 0;
    for (int i = 0; i < W_LEN; i++) begin
      noise();
      step(1, i, 1'b1, 1'b0, 1'b0, 0);
    end
    for (int t = 0; t < nt; t++) begin
      exp_tile = t;
      for (int j = 0; j < I_LEN; j++) begin
        noise();
        step(2, W_LEN + t * I_LEN + j, 1'b1, 1'b0, 1'b0, t);
      end
      start = 1'b0;
      com_end = 1'b0;
      if (t == to_tile) begin
        for (int c = 0; c < TO; c++) step(0, 0, 1'b1, 1'b0, 1'b0, t);
        step(0, 0, 1'b0, 1'b0, 1'b1, t);
        return;
      end
      k = (fixed_k >= 0) ? fixed_k : int'($urandom_range(0, 30));
      for (int c = 0; c < k; c++) step(0, 0, 1'b1, 1'b0, 1'b0, t);
      com_end = 1'b1;
      step(0, 0, 1'b1, 1'b0, 1'b0, t);
      com_end = 1'b0;
    end
    step(0, 0, 1'b0, 1'b1, 1'b0, nt - 1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    num_tile = 8'd0;
    com_end = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_mem_rd", int'(mem_rd), 0);
    check("rst_addr", int'(mem_addr), 0);
    check("rst_tile", int'(tile_idx), 0);
    check("rst_err", int'(err), 0);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    step(0, 0, 1'b0, 1'b0, 1'b0, 0);

    // single tile, com_end 27 cycles into WAIT (cycle 300 relative to start)
    run_job(1, 1'b0, -1, 27);
    idle(2, 1'b0);
    run_job(3, 1'b0, -1, -1);
    idle(2, 1'b0);
    run_job(0, 1'b0, -1, -1);
    idle(1, 1'b0);
    // timeout on second tile, sticky err, restart from ERR
    run_job(2, 1'b0, 1, -1);
    idle(3, 1'b1);
    run_job(1, 1'b1, -1, -1);
    idle(1, 1'b0);
    // com_end in the very cycle the timer expires
    run_job(1, 1'b0, -1, TO - 1);
    idle(1, 1'b0);

    // asynchronous reset in the middle of I_RD
    start = 1'b1;
    num_tile = 8'd2;
    step(0, 0, 1'b0, 1'b0, 1'b0, exp_tile);
    start = 1'b0;
    for (int i = 0; i < W_LEN; i++) step(1, i, 1'b1, 1'b0, 1'b0, 0);
    for (int j = 0; j < 40; j++) step(2, W_LEN + j, 1'b1, 1'b0, 1'b0, 0);
    #2 reset = 1'b1;
    #1;
    check("arst_mem_rd", int'(mem_rd), 0);
    check("arst_addr", int'(mem_addr), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_iload", int'(i_load), 0);
    check("arst_iin", int'(i_in), 0);
    check("arst_tile", int'(tile_idx), 0);
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    prev_ph = 0;
    exp_tile = 0;
    step(0, 0, 1'b0, 1'b0, 1'b0, 0);
    run_job(1, 1'b0, -1, -1);

    for (int r = 0; r < 3; r++) begin
      idle(int'($urandom_range(1, 3)), 1'b0);
      run_job(int'($urandom_range(0, 4)), 1'b0, -1, -1);
    end
    idle(2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/comp_ctrl.md
COMP_CTRL -- requirements
Module: comp_ctrl

Interface
REQ-001 SHALL have parameter W_LEN, default 16, meaning weight words loaded per job.
REQ-002 SHALL have parameter I_LEN, default 256, meaning input words per tile (SIZE*SIZE, with SIZE = FRT+PAD = 16).
REQ-003 SHALL have parameter TIMEOUT, default 4096, meaning the maximum WAIT cycles before error.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, job request, sampled only in IDLE or ERR.
REQ-007 SHALL have port num_tile, input, 8, tile count, captured at accepted start.
REQ-008 SHALL have port mem_rd, output, 1, source-memory read enable.
REQ-009 SHALL have port mem_addr, output, 16, source-memory read address.
REQ-010 SHALL have port mem_rdata, input, 16 signed, read data, valid 1 cycle after mem_rd.
REQ-011 SHALL have ports w_load, output, 1 and w_in, output, 16 signed: weight strobe and data to the computation block.
REQ-012 SHALL have ports i_load, output, 1 and i_in, output, 16 signed: input strobe and data to the computation block.
REQ-013 SHALL have port com_end, input, 1, tile-complete flag from the computation block.
REQ-014 SHALL have ports busy, output, 1; done, output, 1 (one-cycle pulse); err, output, 1 (sticky); tile_idx, output, 8 (current tile).

Function
REQ-015 SHALL implement the states IDLE, W_RD, I_RD, WAIT, DONE and ERR.
REQ-016 IDLE: start=1 SHALL capture num_tile (0 treated as 1), clear tile_idx, and move to W_RD; busy SHALL be 1 from W_RD through WAIT.
REQ-017 W_RD: mem_rd=1 for W_LEN consecutive cycles, mem_addr = 0..W_LEN-1, then go directly to I_RD with no bubble.
REQ-018 I_RD: mem_rd=1 for I_LEN consecutive cycles, mem_addr = W_LEN + tile_idx*I_LEN + j, j = 0..I_LEN-1, then go to WAIT.
REQ-019 Address arithmetic SHALL be 16-bit, wrapping modulo 2^16.
REQ-020 w_load/i_load SHALL be a 1-cycle registered delay of mem_rd tagged by phase; w_in/i_in = mem_rdata while the matching load is 1, else 0.
REQ-021 w_load and i_load SHALL never be 1 in the same cycle.
REQ-022 WAIT: a cycle counter SHALL start at 0 on entry; com_end SHALL be honoured only in WAIT and ignored in every other state.
REQ-023 WAIT with com_end=1 and tile_idx < ntile-1: tile_idx SHALL increment and the state SHALL go to I_RD; weights SHALL NOT be re-read.
REQ-024 WAIT with com_end=1 and tile_idx = ntile-1: the state SHALL go to DONE.
REQ-025 WAIT with the counter reaching TIMEOUT and no com_end: the state SHALL go to ERR.
REQ-026 If com_end and timeout occur in the same cycle, com_end SHALL win.
REQ-027 DONE: lasts 1 cycle, done=1, busy=0, then IDLE.
REQ-028 ERR: err=1, busy=0; start SHALL clear err and begin a new job exactly as from IDLE.
REQ-029 start while busy=1 SHALL be ignored.

Reset
REQ-030 While reset=1, the state SHALL be IDLE immediately (asynchronous), including when reset is asserted mid-operation.
REQ-031 While reset=1, all outputs, counters, tile_idx and the captured tile count SHALL be 0.
REQ-032 After reset deasserts, the first start SHALL be honoured on the next rising edge.

Verification
REQ-033 Single tile: start at cycle 0, num_tile=1 -> mem_rd cycles 1..272, mem_addr 0..271 consecutive, w_load cycles 2..17, i_load cycles 18..273, com_end at cycle 300 -> done=1 and busy=0 at cycle 301.
REQ-034 Multi-tile: num_tile=3 -> weight addresses 0..15 read once, tile addresses 16..271 / 272..527 / 528..783, tile_idx 0/1/2, one done pulse after the third com_end.
REQ-035 num_tile=0 -> behaviour identical to num_tile=1.
REQ-036 Timeout: com_end held 0 -> err=1 and busy=0 after TIMEOUT cycles in WAIT; a later start clears err and mem_addr restarts at 0.
REQ-037 Ignored events: start pulsed during I_RD and com_end pulsed during W_RD -> no state, address or tile_idx disturbance.
REQ-038 Reset mid-I_RD -> all outputs 0 in the same cycle, state IDLE; a new start reloads weights from address 0.
